// File: rtl/lcd_stream_arbiter.sv
// lcd_stream_arbiter: buffers two receive byte streams and shares one PmodCLS SPI
// byte channel between them. Stream 1 is shown on line 0 and stream 2 on line 1.
// A cursor-position escape is inserted before a data byte whenever the line
// changes, or after a column wrap or a carriage return.
//
// state | meaning
// IDLE  | nothing pending, slave_select high
// ARB   | pick the next stream round-robin, slave_select low
// ESC   | first cycle of an escape byte transfer (begin_transmission high)
// DATA  | first cycle of a data byte transfer (begin_transmission high)
// WAIT  | waiting for end_transmission of the current byte
// REL   | slave_select high for one cycle between grants
module lcd_stream_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int COLS       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data1,
    input  logic       rx_data_rdy1,
    input  logic [7:0] rx_data2,
    input  logic       rx_data_rdy2,
    input  logic       end_transmission,
    output logic       begin_transmission,
    output logic [7:0] send_data,
    output logic       slave_select,
    output logic       overflow1,
    output logic       overflow2,
    output logic       busy
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CNW = AW + 1;
    localparam logic [CNW-1:0] DEPTH_CNT = CNW'(FIFO_DEPTH);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);

    typedef enum logic [2:0] {IDLE, ARB, ESC, DATA, WAIT, REL} state_t;

    state_t         state;
    logic [7:0]     mem [2][FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr [2];
    logic [AW-1:0]  rd_ptr [2];
    logic [CNW-1:0] cnt [2];
    logic [7:0]     din [2];
    logic [1:0]     rdy, push, pop, full, nonempty, ovf, need_pos;
    logic [6:0]     col [2];
    logic           last_ch, last_vld, cur_ch, in_esc;
    logic [2:0]     esc_idx, esc_len;
    logic           pick, pick_vld, esc_need, esc_done, two_dig;
    logic           load_go, load_ch, pending;
    logic [6:0]     cur_col, tens, units;
    logic [7:0]     esc_byte, head;

    assign rdy       = {rx_data_rdy2, rx_data_rdy1};
    assign din[0]    = rx_data1;
    assign din[1]    = rx_data2;
    assign overflow1 = ovf[0];
    assign overflow2 = ovf[1];
    assign busy      = (state != IDLE);

    // FIFO status; the full test uses the registered count, ignoring a same-cycle pop
    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int i = 0; i < 2; i++) begin
            full[i]     = (cnt[i] == DEPTH_CNT);
            nonempty[i] = (cnt[i] != '0);
            push[i]     = rdy[i] && !full[i];
        end
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= din[i];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                cnt[i] <= cnt[i] + CNW'(push[i]) - CNW'(pop[i]);
                if (rdy[i] && full[i]) ovf[i] <= 1'b1;
            end
        end
    end

    // Round-robin pick: the stream not served last wins a tie
    always_comb begin
        pick_vld = |nonempty;
        if (&nonempty) pick = last_vld ? ~last_ch : 1'b0;
        else           pick = nonempty[1];
        esc_need = !last_vld || (pick != last_ch) || need_pos[pick];
    end

    // Cursor escape byte generator: ESC [ row ; col H, column in plain decimal
    always_comb begin
        cur_col  = col[cur_ch];
        two_dig  = (cur_col >= 7'd10);
        tens     = cur_col / 7'd10;
        units    = cur_col % 7'd10;
        esc_len  = two_dig ? 3'd7 : 3'd6;
        esc_done = (esc_idx == esc_len);
        case (esc_idx)
            3'd0:    esc_byte = 8'h1B;
            3'd1:    esc_byte = 8'h5B;
            3'd2:    esc_byte = cur_ch ? 8'h31 : 8'h30;
            3'd3:    esc_byte = 8'h3B;
            3'd4:    esc_byte = 8'h30 + (two_dig ? {1'b0, tens} : {1'b0, units});
            3'd5:    esc_byte = two_dig ? (8'h30 + {1'b0, units}) : 8'h48;
            default: esc_byte = 8'h48;
        endcase
    end

    // Head-of-FIFO load: straight from ARB, or once the escape has finished
    always_comb begin
        load_go = ((state == ARB) && pick_vld && !esc_need) ||
                  ((state == WAIT) && end_transmission && in_esc && esc_done);
        load_ch = (state == ARB) ? pick : cur_ch;
        head    = mem[load_ch][rd_ptr[load_ch]];
        pop     = '0;
        if (load_go) pop[load_ch] = 1'b1;
        pending = pick_vld || rx_data_rdy1 || rx_data_rdy2;
    end

    // Sequencer FSM with registered SPI-side outputs and per-line cursor state
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            begin_transmission <= 1'b0;
            send_data          <= 8'h00;
            slave_select       <= 1'b1;
            col[0]             <= '0;
            col[1]             <= '0;
            need_pos           <= 2'b11;
            last_ch            <= 1'b0;
            last_vld           <= 1'b0;
            cur_ch             <= 1'b0;
            in_esc             <= 1'b0;
            esc_idx            <= '0;
        end else begin
            begin_transmission <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        state        <= ARB;
                        slave_select <= 1'b0;
                    end
                end
                ARB: begin
                    if (!pick_vld) begin
                        state        <= IDLE;
                        slave_select <= 1'b1;
                    end else begin
                        cur_ch <= pick;
                        if (esc_need) begin
                            state              <= ESC;
                            begin_transmission <= 1'b1;
                            send_data          <= 8'h1B;
                            esc_idx            <= 3'd1;
                            in_esc             <= 1'b1;
                        end
                    end
                end
                ESC, DATA: state <= WAIT;
                WAIT: begin
                    if (end_transmission) begin
                        if (in_esc && !esc_done) begin
                            state              <= ESC;
                            begin_transmission <= 1'b1;
                            send_data          <= esc_byte;
                            esc_idx            <= esc_idx + 3'd1;
                        end else if (in_esc) begin
                            need_pos[cur_ch] <= 1'b0;
                            in_esc           <= 1'b0;
                        end else begin
                            state        <= REL;
                            slave_select <= 1'b1;
                            last_ch      <= cur_ch;
                            last_vld     <= 1'b1;
                        end
                    end
                end
                REL: begin
                    if (pending) begin
                        state        <= ARB;
                        slave_select <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A carriage return is consumed silently and ends the grant
            if (load_go) begin
                in_esc <= 1'b0;
                if (head == 8'h0D) begin
                    col[load_ch]      <= '0;
                    need_pos[load_ch] <= 1'b1;
                    state             <= REL;
                    slave_select      <= 1'b1;
                    last_ch           <= load_ch;
                    last_vld          <= 1'b1;
                end else begin
                    state              <= DATA;
                    begin_transmission <= 1'b1;
                    send_data          <= head;
                    if (col[load_ch] == COL_LAST) begin
                        col[load_ch]      <= '0;
                        need_pos[load_ch] <= 1'b1;
                    end else begin
                        col[load_ch] <= col[load_ch] + 7'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_stream_arbiter.sv
// Testbench for lcd_stream_arbiter: table of push/expected-byte-stream vectors
// plus directed sequences for latency, overflow and reset during an escape.
module tb_lcd_stream_arbiter;
    logic       clk = 1'b0;
    logic       rst, rdy1, rdy2, end_force, end_model, end_tx, stall;
    logic [7:0] data1, data2;
    logic       begin_transmission, slave_select, overflow1, overflow2, busy;
    logic [7:0] send_data;

    int         checks = 0;
    int         errors = 0;
    int         nbegin = 0;
    int         ss_bad = 0;
    logic [7:0] cap[$];
    bit         pending = 0;
    int         dly = 0;

    typedef struct {
        bit           r;
        bit           v1;
        logic [7:0]   d1;
        bit           v2;
        logic [7:0]   d2;
        int           n;
        logic [127:0] seq;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;
    assign end_tx = end_model | end_force;

    lcd_stream_arbiter #(.FIFO_DEPTH(8), .COLS(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_data1           (data1),
        .rx_data_rdy1       (rdy1),
        .rx_data2           (data2),
        .rx_data_rdy2       (rdy2),
        .end_transmission   (end_tx),
        .begin_transmission (begin_transmission),
        .send_data          (send_data),
        .slave_select       (slave_select),
        .overflow1          (overflow1),
        .overflow2          (overflow2),
        .busy               (busy)
    );

    // SPI transmitter model: captures each begun byte, answers with end after a delay
    initial begin
        end_model = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            end_model = 1'b0;
            if (rst) begin
                pending = 0;
            end else if (begin_transmission) begin
                cap.push_back(send_data);
                nbegin++;
                if (slave_select !== 1'b0) ss_bad++;
                pending = 1;
                dly = 3;
            end else if (pending && !stall) begin
                if (dly == 0) begin
                    end_model = 1'b1;
                    pending = 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic void add(input bit r, input bit v1, input logic [7:0] d1,
                                input bit v2, input logic [7:0] d2, input int n,
                                input logic [127:0] seq);
        vec_t v;
        v.r = r; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.n = n; v.seq = seq;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rdy1 = 1'b0; rdy2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic chk_cap(input string name, input int n, input logic [127:0] seq);
        logic [127:0] got = '0;
        foreach (cap[k]) got = {got[119:0], cap[k]};
        chk({name, "_len"}, 128'(cap.size()), 128'(n));
        chk({name, "_bytes"}, got, seq);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        if (v.r) do_reset();
        cap.delete();
        @(negedge clk);
        rdy1 = v.v1; data1 = v.d1; rdy2 = v.v2; data2 = v.d2;
        @(negedge clk);
        rdy1 = 1'b0; rdy2 = 1'b0;
        wait_idle(name, 500);
        chk_cap(name, v.n, v.seq);
    endtask

    initial begin
        int k;
        int nb0;
        rst = 1'b1; rdy1 = 1'b0; rdy2 = 1'b0; data1 = '0; data2 = '0;
        stall = 1'b0; end_force = 1'b0;

        add(1, 1, 8'h41, 0, 8'h00, 7, 56'h1B5B303B304841);
        add(0, 1, 8'h42, 0, 8'h00, 1, 8'h42);
        add(0, 0, 8'h00, 1, 8'h61, 7, 56'h1B5B313B304861);
        add(0, 1, 8'h43, 0, 8'h00, 7, 56'h1B5B303B324843);
        add(0, 1, 8'h0D, 0, 8'h00, 0, 0);
        add(0, 1, 8'h44, 0, 8'h00, 7, 56'h1B5B303B304844);
        add(0, 0, 8'h00, 1, 8'h0D, 6, 48'h1B5B313B3148);
        add(0, 0, 8'h00, 1, 8'h62, 7, 56'h1B5B313B304862);
        add(1, 1, 8'h0D, 0, 8'h00, 6, 48'h1B5B303B3048);
        add(0, 1, 8'h45, 1, 8'h61, 14, 112'h1B5B313B304861_1B5B303B304845);
        add(0, 1, 8'h46, 0, 8'h00, 1, 8'h46);
        add(1, 1, 8'h30, 0, 8'h00, 7, 56'h1B5B303B304830);
        for (int i = 1; i < 12; i++) begin
            logic [7:0] b;
            b = 8'(8'h30 + i);
            add(0, 1, b, 0, 8'h00, 1, 128'(b));
        end
        add(0, 0, 8'h00, 1, 8'h70, 7, 56'h1B5B313B304870);
        add(0, 1, 8'h4D, 0, 8'h00, 8, 64'h1B5B303B3132484D);
        add(0, 1, 8'h4E, 0, 8'h00, 1, 8'h4E);
        add(0, 1, 8'h4F, 0, 8'h00, 1, 8'h4F);
        add(0, 1, 8'h50, 0, 8'h00, 1, 8'h50);
        add(0, 1, 8'h51, 0, 8'h00, 7, 56'h1B5B303B304851);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // reset values after traffic
        do_reset();
        chk("rst_begin", 128'(begin_transmission), 128'(0));
        chk("rst_send_data", 128'(send_data), 128'(0));
        chk("rst_ss", 128'(slave_select), 128'(1));
        chk("rst_ovf1", 128'(overflow1), 128'(0));
        chk("rst_ovf2", 128'(overflow2), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));

        // end_transmission outside WAIT is ignored
        nb0 = nbegin;
        end_force = 1'b1;
        @(negedge clk);
        end_force = 1'b0;
        @(negedge clk);
        chk("stray_end_busy", 128'(busy), 128'(0));
        chk("stray_end_begins", 128'(nbegin), 128'(nb0));

        // latency: strobe, ARB with select low, then first begin
        cap.delete();
        rdy1 = 1'b1; data1 = 8'h41;
        @(negedge clk);
        rdy1 = 1'b0;
        chk("lat_arb_ss", 128'(slave_select), 128'(0));
        chk("lat_arb_busy", 128'(busy), 128'(1));
        chk("lat_arb_begin", 128'(begin_transmission), 128'(0));
        @(negedge clk);
        chk("lat_begin", 128'(begin_transmission), 128'(1));
        chk("lat_first_byte", 128'(send_data), 128'h1B);
        wait_idle("lat", 500);
        chk("lat_ss_after", 128'(slave_select), 128'(1));
        chk_cap("lat", 7, 56'h1B5B303B304841);

        // overflow: stall the SPI side and push 9 bytes into an 8-deep FIFO
        do_reset();
        cap.delete();
        stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rdy2 = 1'b1; data2 = 8'(8'h80 + i);
        end
        @(negedge clk);
        rdy2 = 1'b0;
        repeat (20) @(negedge clk);
        chk("ovf_set2", 128'(overflow2), 128'(1));
        chk("ovf_clear1", 128'(overflow1), 128'(0));
        chk("ovf_stalled_begins", 128'(cap.size()), 128'(1));
        stall = 1'b0;
        wait_idle("ovf_drain", 1000);
        chk_cap("ovf_drain", 14, 112'h1B5B313B3048_8081828384858687);
        chk("ovf_sticky2", 128'(overflow2), 128'(1));
        do_reset();
        chk("ovf_rst2", 128'(overflow2), 128'(0));

        // reset in the middle of an escape sequence
        cap.delete();
        @(negedge clk);
        rdy1 = 1'b1; data1 = 8'h41;
        @(negedge clk);
        rdy1 = 1'b0;
        k = 0;
        while (cap.size() < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("resc_reached", 128'(cap.size() >= 3), 128'(1));
        chk("resc_ss_low", 128'(slave_select), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("resc_ss", 128'(slave_select), 128'(1));
        chk("resc_begin", 128'(begin_transmission), 128'(0));
        chk("resc_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t v;
            v.r = 0; v.v1 = 1; v.d1 = 8'h42; v.v2 = 0; v.d2 = 8'h00;
            v.n = 7; v.seq = 56'h1B5B303B304842;
            run_vec(v, "resc_restart");
        end

        chk("ss_low_each_begin", 128'(ss_bad), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
